// File: rtl/task_result_serializer.sv
// Buffers result pairs from the task compute block and streams them as bytes to a UART transmitter.
// The AB word goes before the DB word, most-significant byte first. The last byte of a frame is flagged.
module task_result_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic                          i_last,
  input  logic [DATA_WIDTH-1:0]         i_data_AB,
  input  logic [DATA_WIDTH-1:0]         i_data_DB,
  output logic [BYTE_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_tx_last,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int ENTRY_W   = 2*DATA_WIDTH + 1;
  localparam int PAIR_W    = 2*DATA_WIDTH;
  localparam int NUM_BYTES = PAIR_W / BYTE_WIDTH;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               fifo_empty, fifo_full;
  logic               handshake, pop, push, drop;

  state_t             state;
  logic [PAIR_W-1:0]  shift_reg;
  logic               last_flag;
  logic [IDX_W-1:0]   idx;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign handshake  = (state == SEND) && i_tx_ready;
  // Pop either to start from IDLE or back-to-back on the final byte handshake.
  assign pop  = !fifo_empty && ((state == IDLE) || (handshake && idx == IDX_LAST));
  assign push = i_valid && (!fifo_full || pop);
  assign drop = i_valid && fifo_full && !pop;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_last, i_data_AB, i_data_DB};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      last_flag <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= head[PAIR_W-1:0];
            last_flag <= head[ENTRY_W-1];
            idx       <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (idx != IDX_LAST) begin
              idx       <= idx + IDX_W'(1);
              shift_reg <= {shift_reg[PAIR_W-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
            end else if (pop) begin
              shift_reg <= head[PAIR_W-1:0];
              last_flag <= head[ENTRY_W-1];
              idx       <= '0;
            end else begin
              // Clearing the register drives the data output to zero while idle.
              shift_reg <= '0;
              last_flag <= 1'b0;
              idx       <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx_data    = shift_reg[PAIR_W-1 -: BYTE_WIDTH];
  assign o_tx_valid   = (state == SEND);
  assign o_tx_last    = (state == SEND) && (idx == IDX_LAST) && last_flag;
  assign o_fifo_count = count;
  assign o_overflow   = overflow;

endmodule

// File: tb/tb_task_result_serializer.sv
// Directed self-checking bench for task_result_serializer.
// The default parameters are used: 32-bit words, FIFO depth 8, 8 bytes per result pair.
module tb_task_result_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [31:0] i_data_AB = '0;
  logic [31:0] i_data_DB = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        o_tx_last;
  logic [3:0]  o_fifo_count;
  logic        o_overflow;

  int checks = 0;
  int failures = 0;

  task_result_serializer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last),
    .i_data_AB(i_data_AB), .i_data_DB(i_data_DB),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_tx_last(o_tx_last), .o_fifo_count(o_fifo_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] exp_byte(input logic [31:0] ab, input logic [31:0] db, input int k);
    logic [63:0] w;
    w = {ab, db};
    return w[63-8*k -: 8];
  endfunction

  function automatic logic [31:0] ab_of(input int i);
    return {8'(i), 8'hA0, 8'hB0, 8'hC0};
  endfunction

  function automatic logic [31:0] db_of(input int i);
    return {8'(i), 8'h0D, 8'h1D, 8'h2D};
  endfunction

  // Advance past the next rising edge; sampling and driving happen 1 ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_tx_ready = 1'b0;
    i_data_AB = '0; i_data_DB = '0;
    step(); step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic push_pair(input logic [31:0] ab, input logic [31:0] db, input logic last);
    i_valid = 1'b1; i_data_AB = ab; i_data_DB = db; i_last = last;
    step();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step(); step();
    checks++; if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h expected=00", o_tx_data); end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", o_tx_valid); end
    checks++; if (o_tx_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b expected=0", o_tx_last); end
    checks++; if (o_fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d expected=0", o_fifo_count); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", o_overflow); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [31:0] ab = 32'h11223344, db = 32'hAABBCCDD;
    apply_reset();
    i_tx_ready = 1'b1;
    push_pair(ab, db, 1'b1);
    checks++; if (o_fifo_count !== 4'd1) begin failures++; $display("FAIL single_push_count got=%0d expected=1", o_fifo_count); end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b expected=0", o_tx_valid); end
    step();
    for (int k = 0; k < 8; k++) begin
      checks++; if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL single_valid%0d got=%b expected=1", k, o_tx_valid); end
      checks++; if (o_tx_data !== exp_byte(ab, db, k)) begin failures++; $display("FAIL single_data%0d got=%h expected=%h", k, o_tx_data, exp_byte(ab, db, k)); end
      checks++; if (o_tx_last !== (k == 7)) begin failures++; $display("FAIL single_last%0d got=%b expected=%b", k, o_tx_last, (k == 7)); end
      step();
    end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b expected=0", o_tx_valid); end
    checks++; if (o_tx_last !== 1'b0) begin failures++; $display("FAIL single_idle_last got=%b expected=0", o_tx_last); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ab = 32'h11223344, db = 32'hAABBCCDD;
    logic [7:0]  prev_data;
    logic        prev_stall;
    int          hs;
    int          cyc;
    apply_reset();
    push_pair(ab, db, 1'b1);
    step();
    hs = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (hs < 8 && cyc < 100) begin
      i_tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (prev_stall) begin
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data) begin
          failures++; $display("FAIL bp_stable cyc%0d got=%b/%h expected=1/%h", cyc, o_tx_valid, o_tx_data, prev_data);
        end
      end
      if (o_tx_valid && i_tx_ready) begin
        checks++; if (o_tx_data !== exp_byte(ab, db, hs)) begin failures++; $display("FAIL bp_data%0d got=%h expected=%h", hs, o_tx_data, exp_byte(ab, db, hs)); end
        hs++;
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      cyc++;
      step();
    end
    checks++; if (hs !== 8) begin failures++; $display("FAIL bp_handshakes got=%0d expected=8", hs); end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b expected=0", o_tx_valid); end
    i_tx_ready = 1'b0;
  endtask

  task automatic test_burst();
    apply_reset();
    for (int i = 1; i <= 9; i++) push_pair(ab_of(i), db_of(i), 1'b0);
    checks++; if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL burst_count got=%0d expected=8", o_fifo_count); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL burst_no_overflow got=%b expected=0", o_overflow); end
    checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h01) begin failures++; $display("FAIL burst_head got=%b/%h expected=1/01", o_tx_valid, o_tx_data); end
    push_pair(ab_of(10), db_of(10), 1'b0);
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow got=%b expected=1", o_overflow); end
    checks++; if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL burst_count_after_drop got=%0d expected=8", o_fifo_count); end
    i_tx_ready = 1'b1;
    for (int n = 0; n < 72; n++) begin
      checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_byte(ab_of(n/8 + 1), db_of(n/8 + 1), n % 8)) begin
        failures++; $display("FAIL burst_drain%0d got=%b/%h expected=1/%h", n, o_tx_valid, o_tx_data, exp_byte(ab_of(n/8 + 1), db_of(n/8 + 1), n % 8));
      end
      step();
    end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL burst_dropped_sent got=%b expected=0", o_tx_valid); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow_sticky got=%b expected=1", o_overflow); end
    i_tx_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 1; i <= 9; i++) push_pair(ab_of(32 + i), db_of(32 + i), 1'b0);
    i_tx_ready = 1'b1;
    for (int k = 0; k < 7; k++) step();
    checks++; if (o_tx_data !== 8'h2D) begin failures++; $display("FAIL fullpop_byte7 got=%h expected=2d", o_tx_data); end
    push_pair(ab_of(42), db_of(42), 1'b0);
    checks++; if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL fullpop_count got=%0d expected=8", o_fifo_count); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow got=%b expected=0", o_overflow); end
    for (int n = 0; n < 72; n++) begin
      checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_byte(ab_of(n/8 + 34), db_of(n/8 + 34), n % 8)) begin
        failures++; $display("FAIL fullpop_drain%0d got=%b/%h expected=1/%h", n, o_tx_valid, o_tx_data, exp_byte(ab_of(n/8 + 34), db_of(n/8 + 34), n % 8));
      end
      step();
    end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL fullpop_idle got=%b expected=0", o_tx_valid); end
    i_tx_ready = 1'b0;
  endtask

  task automatic test_frame();
    int nbytes, pulses, pos;
    apply_reset();
    push_pair(ab_of(1), db_of(1), 1'b0);
    push_pair(ab_of(2), db_of(2), 1'b0);
    push_pair(ab_of(3), db_of(3), 1'b1);
    i_tx_ready = 1'b1;
    nbytes = 0; pulses = 0; pos = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_tx_valid) begin
        nbytes++;
        if (o_tx_last) begin pulses++; pos = nbytes; end
      end
      step();
    end
    checks++; if (nbytes !== 24) begin failures++; $display("FAIL frame_bytes got=%0d expected=24", nbytes); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL frame_pulses got=%0d expected=1", pulses); end
    checks++; if (pos !== 24) begin failures++; $display("FAIL frame_last_pos got=%0d expected=24", pos); end
    i_tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ab = 32'hCAFEF00D, db = 32'h0BADBEEF;
    apply_reset();
    for (int i = 1; i <= 3; i++) push_pair(ab_of(i), db_of(i), 1'b1);
    i_tx_ready = 1'b1;
    step(); step(); step();
    checks++; if (o_tx_data !== 8'hC0 || o_fifo_count !== 4'd2) begin failures++; $display("FAIL mid_pre got=%h/%0d expected=c0/2", o_tx_data, o_fifo_count); end
    #2 i_rst = 1'b1;
    #1;
    checks++; if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 || o_tx_last !== 1'b0) begin
      failures++; $display("FAIL mid_async_out got=%b/%h/%b expected=0/00/0", o_tx_valid, o_tx_data, o_tx_last);
    end
    checks++; if (o_fifo_count !== 4'd0) begin failures++; $display("FAIL mid_async_count got=%0d expected=0", o_fifo_count); end
    i_tx_ready = 1'b0;
    step(); step();
    i_rst = 1'b0;
    step(); step();
    checks++; if (o_fifo_count !== 4'd0 || o_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_after_count got=%0d/%b expected=0/0", o_fifo_count, o_tx_valid); end
    i_tx_ready = 1'b1;
    push_pair(ab, db, 1'b0);
    step();
    for (int k = 0; k < 8; k++) begin
      checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_byte(ab, db, k)) begin
        failures++; $display("FAIL mid_new%0d got=%b/%h expected=1/%h", k, o_tx_valid, o_tx_data, exp_byte(ab, db, k));
      end
      step();
    end
    checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_new_idle got=%b expected=0", o_tx_valid); end
    i_tx_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_full_pop();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
